dsp_program_sequencer: RTL

Fetches a program of packed DSP instructions from an instruction BRAM and issues them one at a time to the single-instruction DSP controller over its start/valid handshake. Sits between the host (which supplies a base address and length, then pulses nothing: it holds `run_i` like a level request) and the instruction controller, turning a one-instruction engine into a programmable sequence runner.

---
 rtl/dsp_program_sequencer_if.sv | 23 ++
 rtl/dsp_program_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dsp_program_sequencer_if.sv
// Instruction-memory read port and controller start/valid handshake
// between the program sequencer (master) and the BRAM/controller (slave).
interface dsp_program_sequencer_if #(
    parameter int I_WIDTH     = 32,
    parameter int IADDR_WIDTH = 6
);
    logic                   imem_en_o;
    logic [IADDR_WIDTH-1:0] imem_addr_o;
    logic [I_WIDTH-1:0]     imem_data_i;
    logic [I_WIDTH-1:0]     instr_o;
    logic                   ctrl_start_o;
    logic                   ctrl_valid_i;

    modport master (
        output imem_en_o, imem_addr_o, instr_o, ctrl_start_o,
        input  imem_data_i, ctrl_valid_i
    );

    modport slave (
        input  imem_en_o, imem_addr_o, instr_o, ctrl_start_o,
        output imem_data_i, ctrl_valid_i
    );
endinterface

// File: rtl/dsp_program_sequencer.sv
// Program sequencer: fetches packed DSP instructions from the instruction
// BRAM and issues them one at a time to the single-instruction controller.
module dsp_program_sequencer #(
    parameter int I_WIDTH     = 32,
    parameter int IADDR_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   run_i,
    input  logic                   abort_i,
    input  logic [IADDR_WIDTH-1:0] base_addr_i,
    input  logic [IADDR_WIDTH:0]   prog_len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o,
    output logic [IADDR_WIDTH:0]   issued_o,
    dsp_program_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_RELEASE, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [IADDR_WIDTH-1:0] pc_q, pc_d;
    logic [IADDR_WIDTH:0]   rem_q, rem_d;
    logic                   abort_q, abort_d;
    logic [IADDR_WIDTH:0]   issued_q, issued_d;
    logic                   aborted_q, aborted_d;
    logic [I_WIDTH-1:0]     instr_q, instr_d;
    logic                   imem_en_q, start_q, busy_q, done_q;
    logic [IADDR_WIDTH-1:0] imem_addr_q;

    // Next-state, program counter, remaining count and abort bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        pc_d      = pc_q;
        rem_d     = rem_q;
        abort_d   = abort_q;
        issued_d  = issued_q;
        aborted_d = aborted_q;
        instr_d   = instr_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    pc_d      = base_addr_i;
                    rem_d     = prog_len_i;
                    abort_d   = 1'b0;
                    issued_d  = '0;
                    aborted_d = 1'b0;
                    state_d   = (prog_len_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                // Nothing has reached the controller yet, so an abort here ends the run.
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                instr_d = bus.imem_data_i;
                abort_d = abort_q | abort_i;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.ctrl_valid_i) begin
                    issued_d = issued_q + (IADDR_WIDTH + 1)'(1);
                    pc_d     = pc_q + IADDR_WIDTH'(1);
                    rem_d    = rem_q - (IADDR_WIDTH + 1)'(1);
                    // An abort landing with the last completion is a normal finish.
                    abort_d  = abort_q | (abort_i && (rem_q != (IADDR_WIDTH + 1)'(1)));
                    state_d  = S_RELEASE;
                end else begin
                    abort_d = abort_q | abort_i;
                end
            end
            S_RELEASE: begin
                if (!bus.ctrl_valid_i) begin
                    if (abort_q || abort_i) begin
                        aborted_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (rem_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    abort_d = abort_q | abort_i;
                end
            end
            S_DONE: begin
                if (!run_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus outputs registered from the next-state values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            rem_q       <= '0;
            abort_q     <= 1'b0;
            issued_q    <= '0;
            aborted_q   <= 1'b0;
            instr_q     <= '0;
            imem_en_q   <= 1'b0;
            imem_addr_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            pc_q        <= pc_d;
            rem_q       <= rem_d;
            abort_q     <= abort_d;
            issued_q    <= issued_d;
            aborted_q   <= aborted_d;
            instr_q     <= instr_d;
            imem_en_q   <= (state_d == S_FETCH);
            imem_addr_q <= pc_d;
            start_q     <= (state_d == S_ISSUE);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign bus.imem_en_o    = imem_en_q;
    assign bus.imem_addr_o  = imem_addr_q;
    assign bus.instr_o      = instr_q;
    assign bus.ctrl_start_o = start_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign aborted_o        = aborted_q;
    assign issued_o         = issued_q;
endmodule
